des_key_scheduler: RTL and testbench

- Sequential DES/Triple-DES key schedule generator; emits one 48-bit round subkey per accepted handshake.
- Latches up to three 64-bit keys on start and walks 16 rounds per stage.
- Covers encrypt (left rotation) and decrypt (right rotation) order, and the EDE stage sequence.
- Feeds the round datapath in place of the combinational round-indexed key path.

---
 rtl/des_key_pkg.sv | 52 +++++
 rtl/des_key_if.sv | 29 ++
 rtl/des_key_rotate.sv | 18 +
 rtl/des_key_scheduler.sv | 171 +++++++++++++++++
 tb/tb_des_key_scheduler.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/des_key_pkg.sv
// DES key schedule tables, FSM state encoding and PC1/PC2 permutation helpers.
package des_key_pkg;

    localparam int unsigned ROUNDS   = 16;
    localparam int unsigned HALF_W   = 28;
    localparam int unsigned CD_W     = 56;
    localparam int unsigned SUBKEY_W = 48;

    typedef logic [1:0] key_state_t;
    localparam key_state_t ST_IDLE = 2'd0;
    localparam key_state_t ST_RUN  = 2'd1;
    localparam key_state_t ST_DONE = 2'd2;

    // FIPS 46 numbering: entry n selects input bit n counted from the MSB (bit 1).
    localparam int unsigned PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam logic [1:0] SHIFT_TBL [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    function automatic logic [CD_W-1:0] pc1(input logic [63:0] key);
        logic [CD_W-1:0] cd;
        cd = '0;
        for (int i = 0; i < 56; i++) begin
            cd[6'(55 - i)] = key[6'(64 - PC1_TBL[i])];
        end
        return cd;
    endfunction

    function automatic logic [SUBKEY_W-1:0] pc2(input logic [CD_W-1:0] cd);
        logic [SUBKEY_W-1:0] sk;
        sk = '0;
        for (int i = 0; i < 48; i++) begin
            sk[6'(47 - i)] = cd[6'(56 - PC2_TBL[i])];
        end
        return sk;
    endfunction

endpackage

// File: rtl/des_key_if.sv
// Key-scheduler request/subkey bus; master = key consumer/controller, slave = scheduler.
interface des_key_if
    import des_key_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 3
);
    logic                     start;
    logic                     decrypt;
    logic [NUM_STAGES*64-1:0] key_in;
    logic                     subkey_ready;
    logic [SUBKEY_W-1:0]      subkey;
    logic                     subkey_valid;
    logic [3:0]               round_num;
    logic [1:0]               stage_num;
    logic                     stage_decrypt;
    logic                     busy;
    logic                     done;
    logic                     key_err;

    modport master (
        output start, decrypt, key_in, subkey_ready,
        input  subkey, subkey_valid, round_num, stage_num, stage_decrypt, busy, done, key_err
    );

    modport slave (
        input  start, decrypt, key_in, subkey_ready,
        output subkey, subkey_valid, round_num, stage_num, stage_decrypt, busy, done, key_err
    );
endinterface

// File: rtl/des_key_rotate.sv
// 28-bit circular rotate of one key half by 0, 1 or 2 positions, left or right.
module des_key_rotate
    import des_key_pkg::*;
(
    input  logic [HALF_W-1:0] din,
    input  logic              dir_right,
    input  logic [1:0]        amt,
    output logic [HALF_W-1:0] dout_c
);
    always_comb begin
        dout_c = din;
        case (amt)
            2'd1: dout_c = dir_right ? {din[0], din[27:1]}   : {din[26:0], din[27]};
            2'd2: dout_c = dir_right ? {din[1:0], din[27:2]} : {din[25:0], din[27:26]};
            default: dout_c = din;
        endcase
    end
endmodule

// File: rtl/des_key_scheduler.sv
// Sequential DES / 3DES-EDE key schedule: one PC2 subkey per accepted handshake.
// Optional macro DES_KEY_PARITY_CHECK_EN rejects keys whose bytes lack odd parity.
module des_key_scheduler
    import des_key_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 3
) (
    input logic      clk,
    input logic      n_rst,
    des_key_if.slave bus
);
    localparam int unsigned KEY_W      = NUM_STAGES * 64;
    localparam logic [1:0]  LAST_STAGE = 2'(NUM_STAGES - 1);
    localparam logic [3:0]  LAST_ROUND = 4'(ROUNDS - 1);

    key_state_t        state_q, state_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic              dec_q, dec_d;
    logic [HALF_W-1:0] c_q, c_d, d_q, d_d;
    logic [3:0]        round_q, round_d;
    logic [1:0]        stage_q, stage_d;
    logic              sdec_q, sdec_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              key_err_q, key_err_d;

    logic              load_c, adv_c, parity_ok_c;
    logic [1:0]        ld_stage_c, ld_kidx_c;
    logic              ld_blk_dec_c, ld_dec_c;
    logic [KEY_W-1:0]  ld_key_c;
    logic [63:0]       ld_stage_key_c;
    logic [CD_W-1:0]   ld_cd_c;
    logic [HALF_W-1:0] c_rot_in_c, d_rot_in_c, c_rot_c, d_rot_c;
    logic              rot_right_c;
    logic [1:0]        rot_amt_c;

`ifdef DES_KEY_PARITY_CHECK_EN
    always_comb begin
        parity_ok_c = 1'b1;
        for (int b = 0; b < int'(NUM_STAGES) * 8; b++) begin
            parity_ok_c = parity_ok_c & (^bus.key_in[b*8 +: 8]);
        end
    end
`else
    assign parity_ok_c = 1'b1;
`endif

    // Sequencing: start acceptance, round/stage walk and completion.
    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        dec_d     = dec_q;
        round_d   = round_q;
        stage_d   = stage_q;
        key_err_d = 1'b0;
        load_c    = 1'b0;
        adv_c     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (parity_ok_c) begin
                        state_d = ST_RUN;
                        key_d   = bus.key_in;
                        dec_d   = bus.decrypt;
                        round_d = '0;
                        stage_d = '0;
                        load_c  = 1'b1;
                    end else begin
                        key_err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (valid_q && bus.subkey_ready) begin
                    if (round_q != LAST_ROUND) begin
                        round_d = round_q + 4'd1;
                        adv_c   = 1'b1;
                    end else if (stage_q < LAST_STAGE) begin
                        stage_d = stage_q + 2'd1;
                        round_d = '0;
                        load_c  = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        valid_d = (state_d == ST_RUN);
        busy_d  = (state_d == ST_RUN);
        done_d  = (state_d == ST_DONE);
    end

    // Stage key selection: a fresh start reads key_in directly, a stage boundary the latched keys.
    always_comb begin
        ld_stage_c     = (state_q == ST_IDLE) ? 2'd0 : stage_q + 2'd1;
        ld_blk_dec_c   = (state_q == ST_IDLE) ? bus.decrypt : dec_q;
        ld_key_c       = (state_q == ST_IDLE) ? bus.key_in : key_q;
        ld_dec_c       = ld_blk_dec_c ^ ld_stage_c[0];
        ld_kidx_c      = ld_blk_dec_c ? LAST_STAGE - ld_stage_c : ld_stage_c;
        ld_stage_key_c = '0;
        for (int s = 0; s < int'(NUM_STAGES); s++) begin
            if (ld_kidx_c == 2'(s)) ld_stage_key_c = ld_key_c[s*64 +: 64];
        end
        ld_cd_c = pc1(ld_stage_key_c);
    end

    // Decrypt walks the shift table backwards: stepping to round r+1 undoes shift entry 15-r.
    always_comb begin
        if (load_c) begin
            c_rot_in_c  = ld_cd_c[CD_W-1:HALF_W];
            d_rot_in_c  = ld_cd_c[HALF_W-1:0];
            rot_right_c = 1'b0;
            rot_amt_c   = ld_dec_c ? 2'd0 : 2'd1;
        end else begin
            c_rot_in_c  = c_q;
            d_rot_in_c  = d_q;
            rot_right_c = sdec_q;
            rot_amt_c   = sdec_q ? SHIFT_TBL[4'd15 - round_q] : SHIFT_TBL[round_q + 4'd1];
        end
    end

    des_key_rotate u_rot_c (.din(c_rot_in_c), .dir_right(rot_right_c), .amt(rot_amt_c), .dout_c(c_rot_c));
    des_key_rotate u_rot_d (.din(d_rot_in_c), .dir_right(rot_right_c), .amt(rot_amt_c), .dout_c(d_rot_c));

    assign c_d    = (load_c || adv_c) ? c_rot_c : c_q;
    assign d_d    = (load_c || adv_c) ? d_rot_c : d_q;
    assign sdec_d = load_c ? ld_dec_c : sdec_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= ST_IDLE;
            key_q     <= '0;
            dec_q     <= 1'b0;
            c_q       <= '0;
            d_q       <= '0;
            round_q   <= '0;
            stage_q   <= '0;
            sdec_q    <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            key_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            dec_q     <= dec_d;
            c_q       <= c_d;
            d_q       <= d_d;
            round_q   <= round_d;
            stage_q   <= stage_d;
            sdec_q    <= sdec_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            key_err_q <= key_err_d;
        end
    end

    assign bus.subkey        = pc2({c_q, d_q});
    assign bus.subkey_valid  = valid_q;
    assign bus.round_num     = round_q;
    assign bus.stage_num     = stage_q;
    assign bus.stage_decrypt = sdec_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.key_err       = key_err_q;

endmodule

// File: tb/tb_des_key_scheduler.sv
// Self-checking bench for des_key_scheduler: single-DES and 3DES instances against a
// textbook DES key-schedule model (cumulative shifts, reversed order for decrypt stages).
module tb_des_key_scheduler;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    logic         start, dec, ready, sel3;
    logic [191:0] key;

    des_key_if #(.NUM_STAGES(1)) if1 ();
    des_key_if #(.NUM_STAGES(3)) if3 ();

    des_key_scheduler #(.NUM_STAGES(1)) dut1 (.clk(clk), .n_rst(n_rst), .bus(if1.slave));
    des_key_scheduler #(.NUM_STAGES(3)) dut3 (.clk(clk), .n_rst(n_rst), .bus(if3.slave));

    assign if1.start        = start & ~sel3;
    assign if3.start        = start & sel3;
    assign if1.decrypt      = dec;
    assign if3.decrypt      = dec;
    assign if1.key_in       = key[63:0];
    assign if3.key_in       = key;
    assign if1.subkey_ready = ready;
    assign if3.subkey_ready = ready;

    logic [47:0] o_subkey;
    logic [3:0]  o_round;
    logic [1:0]  o_stage;
    logic        o_valid, o_sdec, o_busy, o_done, o_err;
    assign o_subkey = sel3 ? if3.subkey        : if1.subkey;
    assign o_round  = sel3 ? if3.round_num     : if1.round_num;
    assign o_stage  = sel3 ? if3.stage_num     : if1.stage_num;
    assign o_valid  = sel3 ? if3.subkey_valid  : if1.subkey_valid;
    assign o_sdec   = sel3 ? if3.stage_decrypt : if1.stage_decrypt;
    assign o_busy   = sel3 ? if3.busy          : if1.busy;
    assign o_done   = sel3 ? if3.done          : if1.done;
    assign o_err    = sel3 ? if3.key_err       : if1.key_err;

    int checks   = 0;
    int failures = 0;

    int T_PC1 [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                       63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
    int T_PC2 [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                       41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};

    typedef struct packed {
        logic [47:0] sk;
        logic [3:0]  rnd;
        logic [1:0]  stg;
        logic        sdec;
    } exp_t;

    exp_t        exp_q [$];
    logic [47:0] got_q [$];
    logic [47:0] enc_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Encryption subkey K_idx (1..16): C0/D0 rotated left by the cumulative shift count.
    function automatic logic [47:0] ref_subkey(input logic [63:0] k, input int idx);
        logic [55:0] p, cd, t;
        logic [27:0] c, d;
        logic [47:0] sk;
        int          sh;
        for (int j = 0; j < 56; j++) p[6'(55 - j)] = k[6'(64 - T_PC1[j])];
        sh = 0;
        for (int r = 1; r <= idx; r++) sh += (r == 1 || r == 2 || r == 9 || r == 16) ? 1 : 2;
        sh = sh % 28;
        t  = {p[55:28], p[55:28]} << sh;
        c  = t[55:28];
        t  = {p[27:0], p[27:0]} << sh;
        d  = t[55:28];
        cd = {c, d};
        for (int j = 0; j < 48; j++) sk[6'(47 - j)] = cd[6'(56 - T_PC2[j])];
        return sk;
    endfunction

    task automatic build_exp(input int ns, input bit d, input logic [191:0] k);
        exp_t        e;
        logic [63:0] kk;
        bit          sd;
        int          kidx;
        exp_q.delete();
        for (int s = 0; s < ns; s++) begin
            kidx = d ? ns - 1 - s : s;
            sd   = d ^ ((s % 2) == 1);
            kk   = k[kidx*64 +: 64];
            for (int r = 0; r < 16; r++) begin
                e.sk   = ref_subkey(kk, sd ? 16 - r : r + 1);
                e.rnd  = 4'(r);
                e.stg  = 2'(s);
                e.sdec = sd;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"},  64'(o_valid),  64'd0);
        chk({tag, "_busy"},   64'(o_busy),   64'd0);
        chk({tag, "_done"},   64'(o_done),   64'd0);
        chk({tag, "_subkey"}, 64'(o_subkey), 64'd0);
        chk({tag, "_round"},  64'(o_round),  64'd0);
        chk({tag, "_stage"},  64'(o_stage),  64'd0);
        chk({tag, "_sdec"},   64'(o_sdec),   64'd0);
        chk({tag, "_err"},    64'(o_err),    64'd0);
    endtask

    // One schedule; stall_pct>0 adds random back-pressure (always one stall at round 15)
    // and random start pulses while running; rst_at>=0 drops n_rst at that subkey index.
    task automatic run_sched(input bit s3, input bit d, input logic [191:0] k,
                             input int stall_pct, input int rst_at);
        int          idx, budget, waited;
        bit          acc;
        logic [47:0] sk_now;
        build_exp(s3 ? 3 : 1, d, k);
        got_q.delete();
        @(negedge clk);
        sel3 = s3; dec = d; key = k; start = 1'b1; ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        dec   = ~d;
        key   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        chk("busy_after_start", 64'(o_busy), 64'd1);
        idx = 0; budget = 0; waited = 0;
        while (idx < exp_q.size() && budget < 2000) begin
            budget++;
            chk("valid", 64'(o_valid), 64'd1);
            chk("subkey", 64'(o_subkey), 64'(exp_q[idx].sk));
            chk("round", 64'(o_round), 64'(exp_q[idx].rnd));
            chk("stage", 64'(o_stage), 64'(exp_q[idx].stg));
            chk("stage_decrypt", 64'(o_sdec), 64'(exp_q[idx].sdec));
            if (idx == rst_at) begin
                n_rst = 1'b0;
                #1;
                chk_reset_vals("async_rst");
                @(negedge clk);
                start = 1'b0; ready = 1'b0; n_rst = 1'b1;
                @(negedge clk);
                chk("no_done_after_rst", 64'(o_done), 64'd0);
                return;
            end
            ready = (stall_pct == 0) || (int'($urandom_range(99)) >= stall_pct);
            if (stall_pct > 0 && exp_q[idx].rnd == 4'd15 && waited == 0) ready = 1'b0;
            start  = (stall_pct > 0) ? 1'($urandom_range(1)) : 1'b0;
            acc    = ready;
            sk_now = o_subkey;
            @(negedge clk);
            if (acc) begin
                got_q.push_back(sk_now);
                idx++;
                waited = 0;
            end else begin
                waited++;
            end
        end
        start = 1'b0; ready = 1'b0;
        chk("cycle_budget", 64'(budget < 2000), 64'd1);
        chk("done_pulse", 64'(o_done), 64'd1);
        chk("valid_in_done", 64'(o_valid), 64'd0);
        chk("busy_in_done", 64'(o_busy), 64'd0);
        @(negedge clk);
        chk("done_one_cycle", 64'(o_done), 64'd0);
        chk("valid_idle", 64'(o_valid), 64'd0);
    endtask

    logic [191:0] kat, kat3, rk;

    initial begin
        n_rst = 1'b0; start = 1'b0; dec = 1'b0; ready = 1'b0; sel3 = 1'b0; key = '0;
        repeat (2) @(negedge clk);
        for (int v = 0; v < 2; v++) begin
            sel3 = (v == 1);
            #1;
            chk_reset_vals("reset");
        end
        n_rst = 1'b1;
        @(negedge clk);

        kat  = {128'd0, 64'h133457799BBCDFF1};
        kat3 = {3{64'h133457799BBCDFF1}};

        run_sched(1'b0, 1'b0, kat, 0, -1);
        chk("kat_enc_count", 64'(got_q.size()), 64'd16);
        chk("kat_enc_first", 64'(got_q[0]), 64'h1B02EFFC7072);
        chk("kat_enc_last", 64'(got_q[15]), 64'hCB3D8B0E17F5);
        enc_q = got_q;

        run_sched(1'b0, 1'b1, kat, 0, -1);
        chk("kat_dec_first", 64'(got_q[0]), 64'hCB3D8B0E17F5);
        chk("kat_dec_last", 64'(got_q[15]), 64'h1B02EFFC7072);
        for (int i = 0; i < 16; i++) chk("dec_is_reverse", 64'(got_q[i]), 64'(enc_q[15 - i]));

        run_sched(1'b1, 1'b0, kat3, 0, -1);
        chk("ede_count", 64'(got_q.size()), 64'd48);
        chk("ede_stage1_first", 64'(got_q[16]), 64'hCB3D8B0E17F5);
        chk("ede_stage2_first", 64'(got_q[32]), 64'h1B02EFFC7072);

        repeat (3) begin
            rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run_sched(1'b1, 1'($urandom_range(1)), rk, 35, -1);
        end
        repeat (2) begin
            rk = {128'd0, $urandom, $urandom};
            run_sched(1'b0, 1'($urandom_range(1)), rk, 50, -1);
        end

        rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        run_sched(1'b1, 1'b0, rk, 20, 23);
        run_sched(1'b1, 1'b0, rk, 0, -1);
        chk("post_rst_count", 64'(got_q.size()), 64'd48);

`ifdef DES_KEY_PARITY_CHECK_EN
        @(negedge clk);
        sel3 = 1'b0; dec = 1'b0; key = {128'd0, 64'h133457799BBCDFF0}; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("parity_err", 64'(o_err), 64'd1);
        chk("parity_no_valid", 64'(o_valid), 64'd0);
        chk("parity_no_busy", 64'(o_busy), 64'd0);
        @(negedge clk);
        chk("parity_err_pulse", 64'(o_err), 64'd0);
        chk("parity_still_idle", 64'(o_valid), 64'd0);
`else
        run_sched(1'b0, 1'b0, {128'd0, 64'h133457799BBCDFF0}, 0, -1);
        chk("parity_ignored_count", 64'(got_q.size()), 64'd16);
        for (int i = 0; i < 16; i++) chk("parity_ignored", 64'(got_q[i]), 64'(enc_q[i]));
        chk("key_err_tied", 64'(o_err), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
